// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshakes, a one-entry skid behind the main
// register, a bubble (flush) input and a saturating stall-cycle counter.
module ex_mem_pipe #(
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned PC_W = 32,
  parameter logic [BYTE_W-1:0] NOP_ICODE = BYTE_W'(8'h01),
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [BYTE_W-1:0] ex_icode,
  input  logic [BYTE_W-1:0] ex_rA,
  input  logic [BYTE_W-1:0] ex_rB,
  input  logic [WORD_W-1:0] ex_valA,
  input  logic [PC_W-1:0]   ex_valP,
  input  logic [WORD_W-1:0] ex_valE,
  input  logic              bubble,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [BYTE_W-1:0] mem_icode,
  output logic [BYTE_W-1:0] mem_rA,
  output logic [BYTE_W-1:0] mem_rB,
  output logic [WORD_W-1:0] mem_valA,
  output logic [WORD_W-1:0] mem_valE,
  output logic [PC_W-1:0]   mem_valP,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PAY_W = 3 * BYTE_W + 2 * WORD_W + PC_W;
  localparam logic [PAY_W-1:0] NOP_PAY = {NOP_ICODE, {(PAY_W - BYTE_W){1'b0}}};

  logic [PAY_W-1:0] ex_pay;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             consume;

  assign ex_pay   = {ex_icode, ex_rA, ex_rB, ex_valA, ex_valP, ex_valE};
  assign ex_ready = rst & ~bubble & ~skid_valid_q;
  assign accept   = ex_valid & ex_ready;
  assign consume  = main_valid_q & mem_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (bubble) begin
      main_d       = NOP_PAY;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      // Main slot frees up: the skid entry, being older, always refills it first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = ex_pay;
        main_valid_d = 1'b1;
      end else begin
        main_d       = NOP_PAY;
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = ex_pay;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (main_valid_q && !mem_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= NOP_PAY;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign {mem_icode, mem_rA, mem_rB, mem_valA, mem_valP, mem_valE} = main_q;
  assign mem_valid = main_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: a FIFO-queue reference model checked against a default instance
// and a CNT_W=2 instance sharing the same stimulus.
module tb_ex_mem_pipe;

  localparam int unsigned PAY_W = 120;
  localparam logic [PAY_W-1:0] NOP = {8'h01, 112'd0};

  logic        clk = 1'b0;
  logic        rst, ex_valid, bubble, mem_ready;
  logic [7:0]  ex_icode, ex_rA, ex_rB;
  logic [31:0] ex_valA, ex_valP, ex_valE;
  logic        ex_ready, mem_valid, ex_ready2, mem_valid2;
  logic [7:0]  mem_icode, mem_rA, mem_rB, mem_icode2, mem_rA2, mem_rB2;
  logic [31:0] mem_valA, mem_valE, mem_valP, mem_valA2, mem_valE2, mem_valP2;
  logic [1:0]  occupancy, occupancy2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;
  logic [PAY_W-1:0] obs_pay;

  int checks = 0;
  int errors = 0;

  logic [PAY_W-1:0] mq[$];
  int unsigned      mcnt;
  logic             exp_ready_pre, obs_ready;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_icode(ex_icode), .ex_rA(ex_rA), .ex_rB(ex_rB), .ex_valA(ex_valA),
    .ex_valP(ex_valP), .ex_valE(ex_valE), .bubble(bubble), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_icode(mem_icode), .mem_rA(mem_rA), .mem_rB(mem_rB),
    .mem_valA(mem_valA), .mem_valE(mem_valE), .mem_valP(mem_valP),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ex_mem_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready2),
    .ex_icode(ex_icode), .ex_rA(ex_rA), .ex_rB(ex_rB), .ex_valA(ex_valA),
    .ex_valP(ex_valP), .ex_valE(ex_valE), .bubble(bubble), .mem_valid(mem_valid2),
    .mem_ready(mem_ready), .mem_icode(mem_icode2), .mem_rA(mem_rA2), .mem_rB(mem_rB2),
    .mem_valA(mem_valA2), .mem_valE(mem_valE2), .mem_valP(mem_valP2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  assign obs_pay = {mem_icode, mem_rA, mem_rB, mem_valA, mem_valP, mem_valE};

  function automatic logic [PAY_W-1:0] exp_pay();
    return (mq.size() > 0) ? mq[0] : NOP;
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (mcnt > 65535) ? 16'hffff : mcnt[15:0];
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (mcnt > 3) ? 2'd3 : mcnt[1:0];
  endfunction

  task automatic rand_payload();
    ex_icode = 8'($urandom);
    ex_rA    = 8'($urandom);
    ex_rB    = 8'($urandom);
    ex_valA  = $urandom;
    ex_valP  = $urandom;
    ex_valE  = $urandom;
  endtask

  // One clock: evaluate the model on pre-edge inputs, then apply it after the edge.
  task automatic cycle();
    logic acc, con;
    logic [PAY_W-1:0] pin;
    #1;
    exp_ready_pre = rst & ~bubble & (mq.size() < 2);
    obs_ready     = ex_ready;
    acc = ex_valid & exp_ready_pre;
    con = (mq.size() > 0) & mem_ready;
    pin = {ex_icode, ex_rA, ex_rB, ex_valA, ex_valP, ex_valE};
    @(posedge clk);
    #1;
    if (!rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (mq.size() > 0 && !mem_ready) mcnt++;
      if (bubble) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(pin);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bubble = 1'b1; ex_valid = 1'b1; mem_ready = 1'b0;
    rand_payload();
    cycle();
    cycle();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", mem_valid); end
    checks++; if (mem_icode !== 8'h01) begin errors++; $display("FAIL reset_icode got %h want 01", mem_icode); end
    checks++; if (obs_pay !== NOP) begin errors++; $display("FAIL reset_payload got %h want %h", obs_pay, NOP); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    rst = 1'b1; bubble = 1'b0; ex_valid = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ex_ready); end
  endtask

  task automatic test_stream();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1;
      rand_payload();
      ex_icode = 8'(3 + i);
      cycle();
      checks++; if (mem_valid !== 1'b1 || mem_icode !== 8'(3 + i)) begin
        errors++; $display("FAIL stream_icode[%0d] got v=%0b %h want v=1 %h", i, mem_valid, mem_icode, 8'(3 + i));
      end
      checks++; if (obs_pay !== exp_pay()) begin errors++; $display("FAIL stream_payload[%0d] got %h want %h", i, obs_pay, exp_pay()); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
    end
    ex_valid = 1'b0;
    cycle();
    checks++; if (mem_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL stream_drain got v=%0b occ=%0d want v=0 occ=0", mem_valid, occupancy);
    end
  endtask

  task automatic test_skid();
    mem_ready = 1'b0; ex_valid = 1'b1;
    rand_payload(); ex_valE = 32'h11; cycle();
    rand_payload(); ex_valE = 32'h22; cycle();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occ2 got %0d want 2", occupancy); end
    checks++; if (mem_valE !== 32'h11) begin errors++; $display("FAIL skid_head got %h want 11", mem_valE); end
    rand_payload(); ex_valE = 32'h33; cycle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full got %0b want 0", obs_ready); end
    checks++; if (occupancy !== 2'd2 || mem_valE !== 32'h11) begin
      errors++; $display("FAIL skid_hold got occ=%0d %h want occ=2 11", occupancy, mem_valE);
    end
    mem_ready = 1'b1;
    cycle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_drain got %0b want 0", obs_ready); end
    checks++; if (mem_valE !== 32'h22 || occupancy !== 2'd1) begin
      errors++; $display("FAIL skid_second got %h occ=%0d want 22 occ=1", mem_valE, occupancy);
    end
    cycle();
    checks++; if (mem_valE !== 32'h33 || obs_pay !== exp_pay()) begin
      errors++; $display("FAIL skid_third got %h want 33 (%h)", mem_valE, exp_pay());
    end
    ex_valid = 1'b0;
    cycle();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %0b want 0", mem_valid); end
  endtask

  task automatic test_stall();
    rst = 1'b0; cycle(); rst = 1'b1;
    mem_ready = 1'b0; ex_valid = 1'b1; rand_payload();
    cycle();
    ex_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (stall_cnt !== exp_cnt16() || stall_cnt2 !== exp_cnt2()) begin
        errors++; $display("FAIL stall_step[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt2,
                           exp_cnt16(), exp_cnt2());
      end
    end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_five got %0d want 5", stall_cnt); end
    checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL stall_sat got %0d want 3", stall_cnt2); end
    mem_ready = 1'b1;
    cycle();
    checks++; if (stall_cnt !== 16'd5 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got %0d v=%0b want 5 v=0", stall_cnt, mem_valid);
    end
  endtask

  task automatic test_bubble();
    mem_ready = 1'b0; ex_valid = 1'b1;
    rand_payload(); cycle();
    rand_payload(); cycle();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bubble_fill got %0d want 2", occupancy); end
    bubble = 1'b1; rand_payload(); mem_ready = 1'b1;
    cycle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bubble_ready got %0b want 0", obs_ready); end
    checks++; if (mem_valid !== 1'b0 || obs_pay !== NOP) begin
      errors++; $display("FAIL bubble_nop got v=%0b %h want v=0 %h", mem_valid, obs_pay, NOP);
    end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL bubble_occ got %0d want 0", occupancy); end
    checks++; if (stall_cnt !== exp_cnt16() || stall_cnt === 16'd0) begin
      errors++; $display("FAIL bubble_keeps_stall got %0d want %0d", stall_cnt, exp_cnt16());
    end
    bubble = 1'b0; ex_valid = 1'b0;
    cycle();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bubble_no_accept got %0b want 0", mem_valid); end
  endtask

  task automatic test_reset_full();
    mem_ready = 1'b0; ex_valid = 1'b1;
    rand_payload(); cycle();
    rand_payload(); cycle();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstfull_fill got %0d want 2", occupancy); end
    rst = 1'b0; bubble = 1'b1;
    cycle();
    checks++; if (mem_valid !== 1'b0 || obs_pay !== NOP || occupancy !== 2'd0) begin
      errors++; $display("FAIL rstfull_state got v=%0b %h occ=%0d want v=0 %h occ=0", mem_valid, obs_pay,
                         occupancy, NOP);
    end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
      errors++; $display("FAIL rstfull_stall got %0d/%0d want 0/0", stall_cnt, stall_cnt2);
    end
    rst = 1'b1; bubble = 1'b0; ex_valid = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rstfull_ready got %0b want 1", ex_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ex_valid  = ($urandom % 4) != 0;
      mem_ready = ($urandom % 3) != 0;
      bubble    = ($urandom % 16) == 0;
      rand_payload();
      cycle();
      checks++; if (obs_ready !== exp_ready_pre) begin
        errors++; $display("FAIL rand_ready[%0d] got %0b want %0b", i, obs_ready, exp_ready_pre);
      end
      checks++; if (mem_valid !== (mq.size() > 0) || obs_pay !== exp_pay()) begin
        errors++; $display("FAIL rand_out[%0d] got v=%0b %h want v=%0b %h", i, mem_valid, obs_pay,
                           mq.size() > 0, exp_pay());
      end
      checks++; if (occupancy !== 2'(mq.size())) begin
        errors++; $display("FAIL rand_occ[%0d] got %0d want %0d", i, occupancy, mq.size());
      end
      checks++; if (stall_cnt !== exp_cnt16() || stall_cnt2 !== exp_cnt2()) begin
        errors++; $display("FAIL rand_stall[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt2,
                           exp_cnt16(), exp_cnt2());
      end
    end
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; bubble = 1'b0; mem_ready = 1'b0; mcnt = 0;
    rand_payload();
    test_reset();
    test_stream();
    test_skid();
    test_stall();
    test_bubble();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
